// File: rtl/sa_write_arbiter_pkg.sv
// Shared interconnect definitions for the slave-side write arbiter: AXI field
// widths, master-index width helper and the master-index type.
package sa_write_arbiter_pkg;

   localparam int MST_AMT_DEF           = 2;
   localparam int TRANS_MST_ID_W_DEF    = 5;
   localparam int TRANS_BURST_W_DEF     = 2;
   localparam int TRANS_DATA_LEN_W_DEF  = 3;
   localparam int TRANS_DATA_SIZE_W_DEF = 3;

   // Index width for n masters; a single master still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int MST_ID_W_DEF = idx_width(MST_AMT_DEF);

   typedef logic [MST_ID_W_DEF-1:0] mst_idx_t;

endpackage

// File: rtl/sa_grant_fifo.sv
// In-order FIFO of granted master indices; the head selects the W source.
module sa_grant_fifo
   import sa_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem_r [DEPTH];
   logic [PW:0]  wr_ptr_r;
   logic [PW:0]  rd_ptr_r;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
   assign head  = mem_r[rd_ptr_r[PW-1:0]];

   // Storage and pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push && !full) begin
            mem_r[wr_ptr_r[PW-1:0]] <= din;
            wr_ptr_r                <= wr_ptr_r + (PW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/sa_write_arbiter.sv
// Slave-side AW arbiter with one-entry AW register and grant-FIFO W steering.
// Optional macro SA_WRITE_RR_ARB_EN selects round-robin instead of fixed priority.
module sa_write_arbiter
   import sa_write_arbiter_pkg::*;
#(
   parameter int MST_AMT           = MST_AMT_DEF,
   parameter int W_FIFO_DEPTH      = 4,
   parameter int DATA_WIDTH        = 32,
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
   parameter int TRANS_BURST_W     = TRANS_BURST_W_DEF,
   parameter int TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
   parameter int TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
   parameter int MST_ID_W          = idx_width(MST_AMT),
   parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
   input  logic                                  ACLK_i,
   input  logic                                  ARESETn_i,
   input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_AWID_i,
   input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AWADDR_i,
   input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_AWBURST_i,
   input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AWLEN_i,
   input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_AWSIZE_i,
   input  logic [MST_AMT-1:0]                    dsp_AWVALID_i,
   input  logic [MST_AMT-1:0]                    dsp_AW_outst_full_i,
   output logic [MST_AMT-1:0]                    dsp_AWREADY_o,
   input  logic [DATA_WIDTH*MST_AMT-1:0]         dsp_WDATA_i,
   input  logic [MST_AMT-1:0]                    dsp_WLAST_i,
   input  logic [MST_AMT-1:0]                    dsp_WVALID_i,
   input  logic [MST_AMT-1:0]                    dsp_WDATA_sel_i,
   output logic [MST_AMT-1:0]                    dsp_WREADY_o,
   output logic [TRANS_SLV_ID_W-1:0]             s_AWID_o,
   output logic [ADDR_WIDTH-1:0]                 s_AWADDR_o,
   output logic [TRANS_BURST_W-1:0]              s_AWBURST_o,
   output logic [TRANS_DATA_LEN_W-1:0]           s_AWLEN_o,
   output logic [TRANS_DATA_SIZE_W-1:0]          s_AWSIZE_o,
   output logic                                  s_AWVALID_o,
   input  logic                                  s_AWREADY_i,
   output logic [DATA_WIDTH-1:0]                 s_WDATA_o,
   output logic                                  s_WLAST_o,
   output logic                                  s_WVALID_o,
   input  logic                                  s_WREADY_i
);

   logic [MST_AMT-1:0]  eligible_s;
   logic [MST_ID_W-1:0] search_base_s;
   logic [MST_ID_W-1:0] winner_s;
   logic                found_s;
   logic                accept_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [MST_ID_W-1:0] head_s;
   logic                pop_s;

   assign eligible_s = dsp_AWVALID_i & ~dsp_AW_outst_full_i;

`ifdef SA_WRITE_RR_ARB_EN
   logic [MST_ID_W-1:0] rr_ptr_r;

   // Round-robin pointer moves past the most recent winner.
   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         rr_ptr_r <= '0;
      end else if (accept_s) begin
         rr_ptr_r <= (int'(winner_s) + 1 >= MST_AMT) ? '0 : winner_s + MST_ID_W'(1);
      end
   end

   assign search_base_s = rr_ptr_r;
`else
   assign search_base_s = '0;
`endif

   // First eligible master found searching upward from the base (wrapping).
   always_comb begin
      found_s  = 1'b0;
      winner_s = '0;
      for (int k = 0; k < MST_AMT; k++) begin
         int sum;
         int idx;
         sum = int'(search_base_s) + k;
         idx = (sum >= MST_AMT) ? sum - MST_AMT : sum;
         if (!found_s && eligible_s[idx]) begin
            found_s  = 1'b1;
            winner_s = MST_ID_W'(idx);
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Full FIFO blocks even on a pop cycle so push never depends on the W path.
   assign accept_s = ARESETn_i & found_s & ~fifo_full_s & (~s_AWVALID_o | s_AWREADY_i);

   // One-hot AW accept towards the winning dispatcher.
   always_comb begin
      dsp_AWREADY_o = '0;
      if (accept_s) begin
         dsp_AWREADY_o[winner_s] = 1'b1;
      end else begin
         dsp_AWREADY_o = '0;
      end
   end

   // AW output register: loads on accept, clears valid after the slave takes it.
   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         s_AWVALID_o <= 1'b0;
         s_AWID_o    <= '0;
         s_AWADDR_o  <= '0;
         s_AWBURST_o <= '0;
         s_AWLEN_o   <= '0;
         s_AWSIZE_o  <= '0;
      end else if (accept_s) begin
         s_AWVALID_o <= 1'b1;
         s_AWID_o    <= {winner_s, dsp_AWID_i[int'(winner_s)*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
         s_AWADDR_o  <= dsp_AWADDR_i[int'(winner_s)*ADDR_WIDTH +: ADDR_WIDTH];
         s_AWBURST_o <= dsp_AWBURST_i[int'(winner_s)*TRANS_BURST_W +: TRANS_BURST_W];
         s_AWLEN_o   <= dsp_AWLEN_i[int'(winner_s)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
         s_AWSIZE_o  <= dsp_AWSIZE_i[int'(winner_s)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end else if (s_AWVALID_o && s_AWREADY_i) begin
         s_AWVALID_o <= 1'b0;
      end
   end

   sa_grant_fifo #(
      .DEPTH (W_FIFO_DEPTH),
      .W     (MST_ID_W)
   ) u_grant_fifo (
      .clk   (ACLK_i),
      .rst_n (ARESETn_i),
      .push  (accept_s),
      .pop   (pop_s),
      .din   (winner_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .head  (head_s)
   );

   assign s_WVALID_o = ~fifo_empty_s & dsp_WVALID_i[head_s] & dsp_WDATA_sel_i[head_s];
   assign s_WDATA_o  = dsp_WDATA_i[int'(head_s)*DATA_WIDTH +: DATA_WIDTH];
   assign s_WLAST_o  = dsp_WLAST_i[head_s];
   assign pop_s      = s_WVALID_o & s_WREADY_i & s_WLAST_o;

   // W ready is returned only to the FIFO-head master.
   always_comb begin
      dsp_WREADY_o = '0;
      if (!fifo_empty_s) begin
         dsp_WREADY_o[head_s] = s_WREADY_i & dsp_WDATA_sel_i[head_s];
      end else begin
         dsp_WREADY_o = '0;
      end
   end

endmodule

// File: tb/tb_sa_write_arbiter.sv
// Directed bench for sa_write_arbiter; AW scoreboard plus a grant-order model.
module tb_sa_write_arbiter;
   import sa_write_arbiter_pkg::*;

   localparam int M    = 2;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int IDW  = 5;
   localparam int SIDW = 6;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [IDW*M-1:0] dsp_awid = '0;
   logic [AW*M-1:0]  dsp_awaddr = '0;
   logic [2*M-1:0]   dsp_awburst = '0;
   logic [3*M-1:0]   dsp_awlen = '0;
   logic [3*M-1:0]   dsp_awsize = '0;
   logic [M-1:0]     dsp_awvalid = '0;
   logic [M-1:0]     dsp_outst_full = '0;
   logic [M-1:0]     dsp_awready;
   logic [DW*M-1:0]  dsp_wdata = '0;
   logic [M-1:0]     dsp_wlast = '0;
   logic [M-1:0]     dsp_wvalid = '0;
   logic [M-1:0]     dsp_wsel = '0;
   logic [M-1:0]     dsp_wready;
   logic [SIDW-1:0]  s_awid;
   logic [AW-1:0]    s_awaddr;
   logic [1:0]       s_awburst;
   logic [2:0]       s_awlen;
   logic [2:0]       s_awsize;
   logic             s_awvalid;
   logic             s_awready = 1'b1;
   logic [DW-1:0]    s_wdata;
   logic             s_wlast;
   logic             s_wvalid;
   logic             s_wready = 1'b1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [SIDW-1:0] id;
      logic [AW-1:0]   addr;
      logic [2:0]      len;
   } aw_t;

   aw_t      aw_q[$];
   mst_idx_t gq[$];

   always #5 clk = ~clk;

   sa_write_arbiter dut (
      .ACLK_i              (clk),
      .ARESETn_i           (rst_n),
      .dsp_AWID_i          (dsp_awid),
      .dsp_AWADDR_i        (dsp_awaddr),
      .dsp_AWBURST_i       (dsp_awburst),
      .dsp_AWLEN_i         (dsp_awlen),
      .dsp_AWSIZE_i        (dsp_awsize),
      .dsp_AWVALID_i       (dsp_awvalid),
      .dsp_AW_outst_full_i (dsp_outst_full),
      .dsp_AWREADY_o       (dsp_awready),
      .dsp_WDATA_i         (dsp_wdata),
      .dsp_WLAST_i         (dsp_wlast),
      .dsp_WVALID_i        (dsp_wvalid),
      .dsp_WDATA_sel_i     (dsp_wsel),
      .dsp_WREADY_o        (dsp_wready),
      .s_AWID_o            (s_awid),
      .s_AWADDR_o          (s_awaddr),
      .s_AWBURST_o         (s_awburst),
      .s_AWLEN_o           (s_awlen),
      .s_AWSIZE_o          (s_awsize),
      .s_AWVALID_o         (s_awvalid),
      .s_AWREADY_i         (s_awready),
      .s_WDATA_o           (s_wdata),
      .s_WLAST_o           (s_wlast),
      .s_WVALID_o          (s_wvalid),
      .s_WREADY_i          (s_wready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_aw(input int m, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [2:0] len);
      dsp_awid[m*IDW +: IDW]  = id;
      dsp_awaddr[m*AW +: AW]  = addr;
      dsp_awlen[m*3 +: 3]     = len;
   endtask

   // Expected AW issue and grant order, built from the stimulus the bench drives.
   task automatic expect_grant(input int m, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                               input logic [2:0] len);
      aw_t e;
      e.id   = SIDW'((m << IDW) | int'(id));
      e.addr = addr;
      e.len  = len;
      aw_q.push_back(e);
      gq.push_back(mst_idx_t'(m));
   endtask

   // AW scoreboard: every slave-side AW handshake must match the oldest expectation.
   always @(negedge clk) begin
      aw_t e;
      if (rst_n && s_awvalid && s_awready) begin
         if (aw_q.size() == 0) begin
            chk("aw_unexpected", 64'(1), 64'(0));
         end else begin
            e = aw_q.pop_front();
            chk("aw_id", 64'(s_awid), 64'(e.id));
            chk("aw_addr", 64'(s_awaddr), 64'(e.addr));
            chk("aw_len", 64'(s_awlen), 64'(e.len));
         end
      end
   end

   initial begin
      int m;
      int h;
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_awvalid", 64'(s_awvalid), 64'(0));
      chk("rst_awaddr", 64'(s_awaddr), 64'(0));
      chk("rst_awid", 64'(s_awid), 64'(0));
      chk("rst_wvalid", 64'(s_wvalid), 64'(0));
      chk("rst_wready", 64'(dsp_wready), 64'(0));
      chk("rst_awready", 64'(dsp_awready), 64'(0));
      cyc();
      rst_n = 1'b1;

      // Single AW from master 1, then a four-beat burst
      set_aw(1, 5'd3, 32'h0000_0100, 3'd3);
      dsp_awvalid = 2'b10;
      @(negedge clk);
      chk("t1_awready", 64'(dsp_awready), 64'(2'b10));
      expect_grant(1, 5'd3, 32'h0000_0100, 3'd3);
      cyc();
      dsp_awvalid = 2'b00;
      for (int b = 0; b < 4; b++) begin
         dsp_wvalid = 2'b10;
         dsp_wsel   = 2'b10;
         dsp_wlast  = (b == 3) ? 2'b10 : 2'b00;
         dsp_wdata[DW +: DW] = 32'hA0 + 32'(b);
         @(negedge clk);
         if (b == 0) chk("t1_awvalid_n1", 64'(s_awvalid), 64'(1));
         chk("t1_wvalid", 64'(s_wvalid), 64'(1));
         chk("t1_wdata", 64'(s_wdata), 64'(32'hA0 + 32'(b)));
         chk("t1_wlast", 64'(s_wlast), 64'(b == 3));
         chk("t1_wready", 64'(dsp_wready), 64'(2'b10));
         if (b == 3) void'(gq.pop_front());
         cyc();
      end
      dsp_wvalid = 2'b00;
      @(negedge clk);
      chk("t1_empty_wready", 64'(dsp_wready), 64'(0));
      chk("t1_empty_wvalid", 64'(s_wvalid), 64'(0));
      chk("t1_awvalid_done", 64'(s_awvalid), 64'(0));
      cyc();

      // Both masters request continuously with W stalled: arbitration order, FIFO fills
      dsp_wsel = 2'b00;
      s_wready = 1'b0;
      set_aw(0, 5'd5, 32'h0000_0200, 3'd1);
      set_aw(1, 5'd7, 32'h0000_0300, 3'd2);
      dsp_awvalid = 2'b11;
      for (int i = 0; i < 4; i++) begin
`ifdef SA_WRITE_RR_ARB_EN
         m = i % 2;
`else
         m = 0;
`endif
         @(negedge clk);
         chk("t2_grant", 64'(dsp_awready), 64'(1) << m);
         if (m == 0) expect_grant(0, 5'd5, 32'h0000_0200, 3'd1);
         else        expect_grant(1, 5'd7, 32'h0000_0300, 3'd2);
         cyc();
      end

      // Fifth request stalls while full, including the pop cycle
      set_aw(1, 5'd9, 32'h0000_0500, 3'd0);
      dsp_awvalid = 2'b10;
      @(negedge clk);
      chk("t4_full_stall", 64'(dsp_awready), 64'(0));
      cyc();
      s_wready = 1'b1;
      h = int'(gq[0]);
      dsp_wvalid = 2'b00;
      dsp_wsel   = 2'b00;
      dsp_wlast  = 2'b00;
      dsp_wvalid[h] = 1'b1;
      dsp_wsel[h]   = 1'b1;
      dsp_wlast[h]  = 1'b1;
      dsp_wdata[h*DW +: DW] = 32'hB0;
      @(negedge clk);
      chk("t4_pop_wvalid", 64'(s_wvalid), 64'(1));
      chk("t4_pop_wdata", 64'(s_wdata), 64'(32'hB0));
      chk("t4_stall_pop_cycle", 64'(dsp_awready), 64'(0));
      void'(gq.pop_front());
      cyc();
      dsp_wvalid = 2'b00;
      dsp_wsel   = 2'b00;
      dsp_wlast  = 2'b00;
      @(negedge clk);
      chk("t4_fifth_accept", 64'(dsp_awready), 64'(2'b10));
      expect_grant(1, 5'd9, 32'h0000_0500, 3'd0);
      cyc();
      dsp_awvalid = 2'b00;

      // Drain: single-beat bursts, data must come from the modelled head
      dsp_wdata = {32'hC1, 32'hC0};
      for (int n = 0; n < 8 && gq.size() > 0; n++) begin
         h = int'(gq[0]);
         dsp_wvalid = 2'b11;
         dsp_wsel   = 2'b11;
         dsp_wlast  = 2'b11;
         @(negedge clk);
         chk("drain_wdata", 64'(s_wdata), (h == 1) ? 64'(32'hC1) : 64'(32'hC0));
         chk("drain_wready", 64'(dsp_wready), 64'(1) << h);
         void'(gq.pop_front());
         cyc();
      end
      chk("drain_bound", 64'(gq.size()), 64'(0));
      dsp_wvalid = 2'b00;
      dsp_wsel   = 2'b00;
      dsp_wlast  = 2'b00;

      // Slave AW backpressure for five cycles
      s_awready = 1'b0;
      set_aw(0, 5'd2, 32'h0000_0400, 3'd3);
      dsp_awvalid = 2'b01;
      @(negedge clk);
      chk("t3_accept", 64'(dsp_awready), 64'(2'b01));
      expect_grant(0, 5'd2, 32'h0000_0400, 3'd3);
      cyc();
      set_aw(0, 5'd2, 32'h0000_0404, 3'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_awvalid_hold", 64'(s_awvalid), 64'(1));
         chk("t3_awaddr_hold", 64'(s_awaddr), 64'(32'h0000_0400));
         chk("t3_awid_hold", 64'(s_awid), 64'(6'h02));
         chk("t3_no_accept", 64'(dsp_awready), 64'(0));
         cyc();
      end
      dsp_awvalid = 2'b00;
      s_awready   = 1'b1;
      cyc();

      // Non-head master must not be steered or readied
      dsp_wvalid = 2'b10;
      dsp_wsel   = 2'b11;
      dsp_wlast  = 2'b10;
      dsp_wdata  = {32'hD1, 32'hD0};
      @(negedge clk);
      chk("t5_wvalid_nonhead", 64'(s_wvalid), 64'(0));
      chk("t5_wready_head", 64'(dsp_wready), 64'(2'b01));
      cyc();
      dsp_wvalid = 2'b11;
      dsp_wlast  = 2'b11;
      @(negedge clk);
      chk("t5_wvalid_head", 64'(s_wvalid), 64'(1));
      chk("t5_wdata_head", 64'(s_wdata), 64'(32'hD0));
      void'(gq.pop_front());
      cyc();
      dsp_wvalid = 2'b00;
      dsp_wsel   = 2'b00;
      dsp_wlast  = 2'b00;

      // Outstanding-full master is skipped
      set_aw(0, 5'd1, 32'h0000_0600, 3'd0);
      set_aw(1, 5'd4, 32'h0000_0700, 3'd1);
      dsp_awvalid    = 2'b11;
      dsp_outst_full = 2'b01;
      @(negedge clk);
      chk("t6_outst_skip", 64'(dsp_awready), 64'(2'b10));
      expect_grant(1, 5'd4, 32'h0000_0700, 3'd1);
      cyc();
      dsp_awvalid    = 2'b00;
      dsp_outst_full = 2'b00;
      dsp_wvalid     = 2'b10;
      dsp_wsel       = 2'b10;
      dsp_wdata[DW +: DW] = 32'hE0;
      @(negedge clk);
      chk("t6_beat0", 64'(s_wvalid), 64'(1));
      cyc();

      // Reset mid-burst with requests still asserted
      dsp_awvalid = 2'b11;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_awvalid", 64'(s_awvalid), 64'(0));
      chk("rst_mid_awaddr", 64'(s_awaddr), 64'(0));
      chk("rst_mid_wvalid", 64'(s_wvalid), 64'(0));
      chk("rst_mid_wready", 64'(dsp_wready), 64'(0));
      chk("rst_mid_awready", 64'(dsp_awready), 64'(0));
      gq.delete();
      cyc();
      dsp_awvalid = 2'b00;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_wvalid", 64'(s_wvalid), 64'(0));
      chk("post_rst_wready", 64'(dsp_wready), 64'(0));
      chk("aw_queue_drained", 64'(aw_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
